// File: rtl/fhe_pkg.sv
// Shared constants and types for the NTT / pointwise-multiply / INTT chain.
// Latency: n/a (package).
// Backpressure: n/a (package).
package fhe_pkg;

    localparam int N          = 512;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 9;
    localparam int MODULUS    = 7681;
    localparam int BARRETT_K  = 26;
    localparam int BARRETT_MU = 8736;
    // Inverse of the primitive 512th root 4055 (13^15), and 512^-1 mod q.
    localparam int ROOT_INV   = 2811;
    localparam int N_INV      = 7666;

    typedef logic [DATA_WIDTH-1:0]   coeff_t;
    typedef logic [2*DATA_WIDTH-1:0] prod_t;
    typedef logic [ADDR_WIDTH-1:0]   idx_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_state_t;

    typedef struct packed {
        logic vld;
        logic err;
        idx_t idx;
    } mm_tag_t;

endpackage

// File: rtl/mod_mul_barrett.sv
// Barrett modular multiplier: res = a*b mod MODULUS, forced to 0 when an operand is out of range.
// Latency: 3 cycles (S1 product, S2 quotient estimate, S3 subtract/correct), one operand pair per cycle.
// Backpressure: none; fully pipelined, valid/index/error tags travel with the data.
module mod_mul_barrett
    import fhe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic [ADDR_WIDTH-1:0] in_idx,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_vld,
    output logic                  out_err,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic [DATA_WIDTH-1:0] out_res
);

    // p*MU needs 32 + 14 bits; keep a little headroom.
    localparam int MW = 2*DATA_WIDTH + 16;
    localparam int QW = MW - BARRETT_K;
    localparam prod_t          MOD_P = prod_t'(MODULUS);
    localparam logic [MW-1:0]  MU_W  = MW'(BARRETT_MU);

    mm_tag_t       s1_tag, s2_tag, s3_tag;
    prod_t         s1_p, s2_p;
    logic [QW-1:0] s2_q;
    coeff_t        s3_res;
    logic [MW-1:0] s1_pm;
    prod_t         s2_r, s2_r1, s2_r2;
    logic          in_err;

    assign in_err = (in_a >= coeff_t'(MODULUS)) || (in_b >= coeff_t'(MODULUS));

    always_comb begin
        s1_pm = MW'(s1_p) * MU_W;
        // q underestimates the true quotient by at most 2, so r < 3*MODULUS.
        s2_r  = s2_p - prod_t'(s2_q) * MOD_P;
        s2_r1 = (s2_r  >= MOD_P) ? s2_r  - MOD_P : s2_r;
        s2_r2 = (s2_r1 >= MOD_P) ? s2_r1 - MOD_P : s2_r1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_tag <= '0;
            s2_tag <= '0;
            s3_tag <= '0;
        end else begin
            s1_tag <= '{vld: in_vld, err: in_err, idx: in_idx};
            s2_tag <= s1_tag;
            s3_tag <= s2_tag;
        end
    end

    always_ff @(posedge clk) begin
        s1_p   <= prod_t'(in_a) * prod_t'(in_b);
        s2_p   <= s1_p;
        s2_q   <= s1_pm[MW-1:BARRETT_K];
        s3_res <= s2_tag.err ? '0 : s2_r2[DATA_WIDTH-1:0];
    end

    assign out_vld = s3_tag.vld;
    assign out_err = s3_tag.err;
    assign out_idx = s3_tag.idx;
    assign out_res = s3_res;

endmodule

// File: rtl/ntt_pointwise_mul.sv
// Pointwise product C[i] = A[i]*B[i] mod q of two NTT-domain vectors, one coefficient per cycle.
// Latency: done pulses in the cycle after edge E0+516 (E0 = accepting edge); results retire at E0+4+i.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
module ntt_pointwise_mul
    import fhe_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N*DATA_WIDTH-1:0] a_in,
    input  logic [N*DATA_WIDTH-1:0] b_in,
    output logic                    busy,
    output logic                    done,
    output logic                    range_err,
    output logic [N*DATA_WIDTH-1:0] data_out
);

    localparam idx_t IDX_LAST = idx_t'(N-1);

    fsm_state_t state, state_nxt;
    logic       accept;
    idx_t       idx;
    logic       wr_last;
    coeff_t     a_reg [N];
    coeff_t     b_reg [N];

    logic       mm_vld;
    logic       mm_err;
    idx_t       mm_idx;
    coeff_t     mm_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (idx == IDX_LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Operands are snapshotted so the source may change once the job is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                a_reg[i] <= a_in[i*DATA_WIDTH +: DATA_WIDTH];
                b_reg[i] <= b_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    mod_mul_barrett u_mul (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (state == RUN),
        .in_idx  (idx),
        .in_a    (a_reg[idx]),
        .in_b    (b_reg[idx]),
        .out_vld (mm_vld),
        .out_err (mm_err),
        .out_idx (mm_idx),
        .out_res (mm_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            wr_last   <= 1'b0;
            range_err <= 1'b0;
            data_out  <= '0;
        end else begin
            wr_last <= mm_vld && (mm_idx == IDX_LAST);
            if (mm_vld) begin
                data_out[mm_idx*DATA_WIDTH +: DATA_WIDTH] <= mm_res;
                if (mm_err) begin
                    range_err <= 1'b1;
                end
            end
            // The pipeline is empty whenever a job is accepted, so this never races a retire.
            if (accept) begin
                idx       <= '0;
                range_err <= 1'b0;
            end else if (state == RUN) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule
